uart_prog_loader: RTL
=====================

# uart_prog_loader

Serial boot loader sitting directly upstream of the RV32I core and its program memory. It receives a framed program image over a UART line and writes it word-by-word into program memory through a write port. It holds the core in reset until a complete, checksum-verified image has been stored, then releases it.

## Interface
Parameters:
- CLKS_PER_BIT, 434 — clk cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- AW, 8 — program-memory word-address width; capacity 2**AW words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  UART receive line, idle high, 8N1, LSB first; asynchronous to clk.
- pm_we  out  1  program-memory write strobe, one-cycle pulse per word.
- pm_addr  out  AW  word address for the current write.
- pm_wdata  out  32  instruction word for the current write.
- cpu_hold  out  1  1 = keep core in reset; drives the core's reset.
- done  out  1  image loaded and verified; sticky.
- error  out  1  last frame rejected; sticky until next sync byte.

## Operation
- Frame: sync byte 0xA5, word count N (2 bytes, little-endian), N×4 data bytes (each word little-endian), checksum byte = XOR of all 4N data bytes only (not sync or count).
- Byte receiver: rx passes a 2-flop synchronizer. A falling edge starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the edge is a glitch and the receiver returns to idle. Eight data bits are then sampled at bit centres. The stop bit must be 1, otherwise a framing error is raised and no byte is delivered.
- FSM states: SYNC → LEN_LO → LEN_HI → DATA → CSUM → DONE; ERR reachable from LEN_LO..CSUM.
- SYNC: bytes other than 0xA5 and framing errors are ignored. On 0xA5, go to LEN_LO, clear error, set pm_addr=0, clear checksum.
- LEN_HI: if N > 2**AW, go to ERR. If N = 0, go to CSUM. Otherwise go to DATA.
- DATA: bytes fill the word LSB first. On the 4th byte, pm_wdata is set to the word and pm_we pulses. pm_addr increments by 1 after the pulse. After N words, go to CSUM.
- CSUM: if the received byte equals the running XOR, go to DONE, else go to ERR.
- A framing error in any state from LEN_LO to CSUM forces ERR.
- DONE: cpu_hold=0, done=1. rx is ignored until reset.
- ERR: error=1, cpu_hold=1. Behaves as SYNC, so a 0xA5 restarts the frame.
- Memory already written by a failed frame is not erased; the next good frame overwrites it.

## Timing
- Reset values: pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=1, done=0, error=0, FSM=SYNC, receiver idle. Reset takes effect immediately and asynchronously.
- Reset mid-frame: all partial state is discarded. After release, the loader waits for a fresh 0xA5.
- A byte is delivered 1 cycle after the stop-bit centre sample.
- pm_we is high exactly 1 cycle, in the cycle after the 4th data byte is delivered. pm_addr and pm_wdata are stable during that cycle.
- cpu_hold falls and done rises in the cycle after a correct checksum byte is delivered.
- error rises in the cycle after the offending byte or framing error.
- Within one frame, successive pm_we pulses are at least 4 byte-times apart.

## Structure
- Shared include `loader_defs.vh`: FSM state encodings (3-bit), SYNC_BYTE = 8'hA5.
- Sub-module `uart_rx_byte` contains the synchronizer, bit timer and shift register. Outputs: byte_valid (1-cycle pulse), byte_data[7:0], frame_err (1-cycle pulse). Parameter: CLKS_PER_BIT.
- The top level holds the FSM, word counter, byte-in-word counter, word assembly register and XOR accumulator.

## Test plan
Each scenario uses CLKS_PER_BIT=8.
1. Good 2-word frame. Send bytes A5 02 00 13 00 00 00 93 0F 50 00 DF. Expect:
   - a pm_we pulse with addr 0 / 0x00000013;
   - a pm_we pulse with addr 1 / 0x00500F93;
   - then cpu_hold=0 and done=1.
2. Bad checksum, then recovery. Send the same frame with checksum 00. Expect error=1, cpu_hold=1, done=0. Then resend the good frame: expect error=0 after A5 and done=1 at the end.
3. Framing error. Drive stop bit = 0 on the 2nd data byte. Expect error=1, no further pm_we, FSM in ERR.
4. Empty image. Send A5 00 00 00. Expect no pm_we and done=1. Separately, with AW=4, send A5 11 00 (N=17). Expect error=1.
5. Preamble noise. Send 00 FF 3C, plus a 1/4-bit low glitch, before the frame from scenario 1. Expect no effect and a normal load.
6. Reset mid-frame. Assert reset during the 3rd data byte. Expect all outputs at reset values immediately. After release, a full frame loads starting at pm_addr 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and the frame sync byte.
package uart_prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Program-memory write port driven by the loader.
interface uart_prog_loader_if #(
  parameter int AW = 8
);
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [31:0]   pm_wdata;

  modport master (output pm_we, output pm_addr, output pm_wdata);
  modport slave  (input  pm_we, input  pm_addr, input  pm_wdata);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection, bit-centre sampling.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            r_meta, r_rx, r_rx_prev;
  rx_state_t       r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic [7:0]      r_data, w_data_next;
  logic            r_valid, w_valid_next;
  logic            r_ferr, w_ferr_next;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_valid_next   = 1'b0;
    w_ferr_next    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_next = '0;
        if (r_rx_prev && !r_rx) w_state_next = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rx, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next   = '0;
          w_state_next = RX_IDLE;
          if (r_rx) begin
            w_valid_next = 1'b1;
            w_data_next  = r_shift;
          end else begin
            w_ferr_next = 1'b1;
          end
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta    <= 1'b1;
      r_rx      <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_meta    <= rx;
      r_rx      <= r_meta;
      r_rx_prev <= r_rx;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  assign byte_valid = r_valid;
  assign byte_data  = r_data;
  assign frame_err  = r_ferr;
endmodule

// File: rtl/uart_prog_loader.sv
// Serial boot loader: parses A5/len/data/xor frames from the UART and writes words to program memory.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int AW           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  uart_prog_loader_if.master pm,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

  logic          w_byte_valid, w_frame_err;
  logic [7:0]    w_byte_data;
  logic [15:0]   w_len_full;
  logic [16:0]   w_word_cnt_inc;

  loader_state_t r_state, w_state_next;
  logic [15:0]   r_len, w_len_next;
  logic [16:0]   r_word_cnt, w_word_cnt_next;
  logic [1:0]    r_byte_cnt, w_byte_cnt_next;
  logic [31:0]   r_word, w_word_next;
  logic [7:0]    r_csum, w_csum_next;
  logic          r_pm_we, w_pm_we_next;
  logic [AW-1:0] r_pm_addr, w_pm_addr_next;
  logic [31:0]   r_pm_wdata, w_pm_wdata_next;
  logic          r_error, w_error_next;
  logic          r_done, w_done_next;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  assign w_len_full     = {w_byte_data, r_len[7:0]};
  assign w_word_cnt_inc = r_word_cnt + 17'd1;

  always_comb begin
    w_state_next    = r_state;
    w_len_next      = r_len;
    w_word_cnt_next = r_word_cnt;
    w_byte_cnt_next = r_byte_cnt;
    w_word_next     = r_word;
    w_csum_next     = r_csum;
    w_pm_we_next    = 1'b0;
    w_pm_addr_next  = r_pm_we ? r_pm_addr + 1'b1 : r_pm_addr;
    w_pm_wdata_next = r_pm_wdata;
    w_error_next    = r_error;
    w_done_next     = r_done;
    case (r_state)
      ST_SYNC, ST_ERR: begin
        if (w_byte_valid && w_byte_data == SYNC_BYTE) begin
          w_state_next    = ST_LEN_LO;
          w_error_next    = 1'b0;
          w_pm_addr_next  = '0;
          w_csum_next     = '0;
          w_word_cnt_next = '0;
          w_byte_cnt_next = '0;
        end
      end
      ST_LEN_LO: begin
        if (w_byte_valid) begin
          w_len_next   = {8'h00, w_byte_data};
          w_state_next = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (w_byte_valid) begin
          w_len_next = w_len_full;
          if ({1'b0, w_len_full} > MAX_WORDS) begin
            w_state_next = ST_ERR;
            w_error_next = 1'b1;
          end else if (w_len_full == 16'd0) begin
            w_state_next = ST_CSUM;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_byte_valid) begin
          w_csum_next     = r_csum ^ w_byte_data;
          w_word_next     = {w_byte_data, r_word[31:8]};
          w_byte_cnt_next = r_byte_cnt + 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_pm_wdata_next = {w_byte_data, r_word[31:8]};
            w_pm_we_next    = 1'b1;
            w_word_cnt_next = w_word_cnt_inc;
            if (w_word_cnt_inc == {1'b0, r_len}) w_state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_byte_valid) begin
          if (w_byte_data == r_csum) begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = ST_ERR;
            w_error_next = 1'b1;
          end
        end
      end
      ST_DONE: ;
      default: w_state_next = ST_SYNC;
    endcase
    // A broken byte anywhere inside a frame aborts it.
    if (w_frame_err && (r_state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM})) begin
      w_state_next = ST_ERR;
      w_error_next = 1'b1;
      w_pm_we_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_SYNC;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_len      <= w_len_next;
      r_word_cnt <= w_word_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_word     <= w_word_next;
      r_csum     <= w_csum_next;
      r_pm_we    <= w_pm_we_next;
      r_pm_addr  <= w_pm_addr_next;
      r_pm_wdata <= w_pm_wdata_next;
      r_error    <= w_error_next;
      r_done     <= w_done_next;
    end
  end

  assign pm.pm_we    = r_pm_we;
  assign pm.pm_addr  = r_pm_addr;
  assign pm.pm_wdata = r_pm_wdata;
  assign cpu_hold    = ~r_done;
  assign done        = r_done;
  assign error       = r_error;
endmodule
